pu_result_drain: RTL and testbench
==================================

# pu_result_drain

Result drain stage placed directly downstream of the matrix-vector processing unit. It detects the rising edge of the unit's `DONE`, snapshots the packed `MATRIX_ROW`-word result bus, and streams the words out one per handshake over a valid/ready interface, narrowing each from `WIDTH_OUT` to `WIDTH_RES` bits. This lets the accumulators be cleared and restarted while results are still being consumed.

## Interface
Parameters:
- `WIDTH_OUT`, 32: width of one accumulator word from the processing unit.
- `WIDTH_RES`, 16: width of one streamed result word; must satisfy `WIDTH_RES <= WIDTH_OUT`.
- `MATRIX_ROW`, 8: number of result words per job.

Ports:
- `CLK`, input, 1: single clock; all logic is on the rising edge.
- `RSTN`, input, 1: reset, synchronous and active-low.
- `PU_OUT`, input, `WIDTH_OUT*MATRIX_ROW`: packed results; word k is `[WIDTH_OUT*k +: WIDTH_OUT]`.
- `PU_DONE`, input, 1: done level from the processing unit (stays high until it is reset).
- `M_VALID`, output, 1: result word valid.
- `M_READY`, input, 1: downstream accepts the word.
- `M_DATA`, output, `WIDTH_RES`: narrowed result word.
- `M_IDX`, output, `$clog2(MATRIX_ROW)`: row index of `M_DATA`.
- `M_LAST`, output, 1: high with the word where `M_IDX == MATRIX_ROW-1`.
- `BUSY`, output, 1: a snapshot is held and not yet fully drained.
- `DROP`, output, 1: sticky; a `DONE` edge was lost.
- `CLR_DROP`, input, 1: clears `DROP`.

## Operation
- The internal `done_q` register samples `PU_DONE` every cycle. Edge = `PU_DONE & ~done_q`.
- FSM states:
  - `IDLE`: on an edge, copy all of `PU_OUT` into the snapshot buffer, set `idx = 0`, and go to `SEND`.
  - `SEND`: `M_VALID = 1`. On a handshake (`M_VALID & M_READY`):
    - if `idx == MATRIX_ROW-1`, go to `IDLE`;
    - otherwise `idx++`.
- Words are sent in strict index order 0 to `MATRIX_ROW-1`, and each word appears exactly once.
- An edge that coincides with the handshake of the last word is accepted: the buffer is reloaded, `idx = 0`, and the state stays `SEND`. This allows back-to-back jobs with no bubble.
- An edge at any other point in `SEND` is ignored for data purposes and sets `DROP`. The buffer and `idx` are unaffected.
- `DROP` is cleared by `CLR_DROP`. If `CLR_DROP` and a new drop occur in the same cycle, set wins.
- `M_DATA`, `M_IDX`, `M_LAST`, and `M_VALID` remain stable while `M_VALID & ~M_READY`.
- Narrowing is performed by the `pu_drain_narrow` function (see Configuration). Inputs are treated as two's-complement signed.
- `BUSY` equals `state == SEND`.

## Timing
- Reset values (on a clock edge with `RSTN = 0`):
  - `state = IDLE`, `done_q = 0`, `idx = 0`, `DROP = 0`, buffer = 0;
  - hence `M_VALID = 0`, `M_DATA = 0`, `M_IDX = 0`, `M_LAST = 0`, `BUSY = 0`.
- Reset mid-drain discards the snapshot with no further output. If `PU_DONE` is high while reset is asserted, `done_q` loads 0, so the first cycle after reset sees an edge and captures.
- Latency: edge sampled at clock edge t gives `M_VALID = 1` from cycle t+1, with word 0 presented.
- Throughput: with `M_READY` held high, a full drain takes `MATRIX_ROW` cycles and back-to-back jobs run at 1 word/cycle.
- `M_DATA` is combinational from the buffer and `idx` only; there is no path from `M_READY` to `M_DATA`.

## Configuration
- `PU_DRAIN_SAT_EN` defined: signed saturation.
  - Values above `2^(WIDTH_RES-1)-1` output the maximum positive value.
  - Values below `-2^(WIDTH_RES-1)` output the minimum negative value.
  - Otherwise output the low `WIDTH_RES` bits.
- `PU_DRAIN_SAT_EN` undefined: plain truncation to the low `WIDTH_RES` bits, with no saturation logic synthesised.

## Structure
- Shared package `pu_pkg`:
  - state encoding constants `PU_DRAIN_IDLE`, `PU_DRAIN_SEND`;
  - the `pu_drain_narrow` function, guarded by the macro.
- One sub-module: `pu_drain_buf`. It holds the snapshot buffer, with a load enable, a row-select read port, and a synchronous reset.
- The FSM, `idx` counter, and `DROP` logic stay in the top module.

## Test plan
- Reset then capture: assert `RSTN = 0` for 2 cycles; `PU_OUT` words = 1..8; raise `PU_DONE`; hold `M_READY = 1`.
  - Expect: `M_VALID` from the next cycle, `M_DATA` = 1..8 on consecutive cycles, `M_LAST` only on 8, `BUSY` low afterwards.
- Backpressure: toggle `M_READY` 1/0 every cycle.
  - Expect: each word held stable while stalled, with no duplicates or skips.
- Saturation (`PU_DRAIN_SAT_EN` defined, `WIDTH_RES = 16`): words `0x0001_0000`, `0xFFFE_0000`, `0x0000_7FFF`.
  - Expect: `0x7FFF`, `0x8000`, `0x7FFF`.
  - Without the macro, expect: `0x0000`, `0x0000`, `0x7FFF`.
- Back-to-back: second `DONE` edge on the same cycle as the last handshake.
  - Expect: word 0 of the new job on the next cycle and `DROP` still 0.
- Drop: `DONE` edge while `idx = 3`.
  - Expect: `DROP = 1`, and the drain continues with the original words 4..7.
  - Then pulse `CLR_DROP`; expect `DROP = 0`.
- Reset mid-drain at `idx = 2`: `M_VALID = 0` immediately after reset. `PU_DONE` is still high, so capture occurs on the first post-reset cycle.

Source files
------------

// File: rtl/pu_pkg.sv
// Shared definitions for the PU result drain: FSM state encoding and the word narrowing helper.
// PU_DRAIN_SAT_EN selects signed saturation in pu_drain_narrow; otherwise plain truncation.
package pu_pkg;

    localparam int unsigned PU_NARROW_W = 64;

    typedef enum logic [0:0] {
        PU_DRAIN_IDLE = 1'b0,
        PU_DRAIN_SEND = 1'b1
    } pu_drain_state_e;

`ifdef PU_DRAIN_SAT_EN
    // Clamp a sign-extended word into the signed range of res_w bits.
    function automatic logic signed [PU_NARROW_W-1:0] pu_drain_narrow(
        input logic signed [PU_NARROW_W-1:0] val,
        input int unsigned                   res_w
    );
        logic signed [PU_NARROW_W-1:0] max_v;
        logic signed [PU_NARROW_W-1:0] min_v;
        max_v = (64'sd1 <<< (res_w - 32'd1)) - 64'sd1;
        min_v = ~max_v;
        if (val > max_v) begin
            return max_v;
        end else if (val < min_v) begin
            return min_v;
        end else begin
            return val;
        end
    endfunction
`else
    // Keep only the low res_w bits; the mask folds to a constant slice.
    function automatic logic signed [PU_NARROW_W-1:0] pu_drain_narrow(
        input logic signed [PU_NARROW_W-1:0] val,
        input int unsigned                   res_w
    );
        return val & ((64'sd1 <<< res_w) - 64'sd1);
    endfunction
`endif

endpackage

// File: rtl/pu_drain_buf.sv
// Snapshot buffer for one job of PU results: parallel load, one-word row-select read.
module pu_drain_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     load,
    input  logic [WIDTH*DEPTH-1:0]   din,
    input  logic [$clog2(DEPTH)-1:0] sel,
    output logic [WIDTH-1:0]         dout
);

    logic [WIDTH*DEPTH-1:0] buf_q;

    // Snapshot register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            buf_q <= '0;
        end else if (load) begin
            buf_q <= din;
        end else begin
            buf_q <= buf_q;
        end
    end

    assign dout = buf_q[WIDTH*sel +: WIDTH];

endmodule

// File: rtl/pu_result_drain.sv
// Captures the PU result bus on a rising DONE and streams it out word by word over valid/ready.
// PU_DRAIN_SAT_EN enables signed saturation of each word; default build truncates.
module pu_result_drain
    import pu_pkg::*;
#(
    parameter int unsigned WIDTH_OUT  = 32,
    parameter int unsigned WIDTH_RES  = 16,
    parameter int unsigned MATRIX_ROW = 8
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic [WIDTH_OUT*MATRIX_ROW-1:0] PU_OUT,
    input  logic                          PU_DONE,
    output logic                          M_VALID,
    input  logic                          M_READY,
    output logic [WIDTH_RES-1:0]          M_DATA,
    output logic [$clog2(MATRIX_ROW)-1:0] M_IDX,
    output logic                          M_LAST,
    output logic                          BUSY,
    output logic                          DROP,
    input  logic                          CLR_DROP
);

    localparam int unsigned IDX_W = $clog2(MATRIX_ROW);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MATRIX_ROW - 1);

    pu_drain_state_e  state_q;
    logic             done_q;
    logic [IDX_W-1:0] idx_q;
    logic             drop_q;

    logic                          edge_s;
    logic                          hs_s;
    logic                          last_s;
    logic                          reload_s;
    logic                          load_s;
    logic                          drop_set_s;
    logic [WIDTH_OUT-1:0]          rd_word_s;
    logic signed [PU_NARROW_W-1:0] word_ext_s;

    assign edge_s     = PU_DONE & ~done_q;
    assign last_s     = (idx_q == IDX_LAST);
    assign hs_s       = (state_q == PU_DRAIN_SEND) & M_READY;
    // A new job may only land in the cycle the last word leaves.
    assign reload_s   = hs_s & last_s;
    assign load_s     = edge_s & ((state_q == PU_DRAIN_IDLE) | reload_s);
    assign drop_set_s = edge_s & (state_q == PU_DRAIN_SEND) & ~reload_s;

    pu_drain_buf #(
        .WIDTH (WIDTH_OUT),
        .DEPTH (MATRIX_ROW)
    ) u_buf (
        .clk  (CLK),
        .rstn (RSTN),
        .load (load_s),
        .din  (PU_OUT),
        .sel  (idx_q),
        .dout (rd_word_s)
    );

    // Drain FSM, row counter, done edge detector and sticky drop flag.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= PU_DRAIN_IDLE;
            done_q  <= 1'b0;
            idx_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            done_q <= PU_DONE;
            case (state_q)
                PU_DRAIN_IDLE: begin
                    if (edge_s) begin
                        state_q <= PU_DRAIN_SEND;
                        idx_q   <= '0;
                    end else begin
                        state_q <= PU_DRAIN_IDLE;
                        idx_q   <= idx_q;
                    end
                end
                PU_DRAIN_SEND: begin
                    if (hs_s && last_s) begin
                        state_q <= edge_s ? PU_DRAIN_SEND : PU_DRAIN_IDLE;
                        idx_q   <= '0;
                    end else if (hs_s) begin
                        state_q <= PU_DRAIN_SEND;
                        idx_q   <= idx_q + IDX_W'(1);
                    end else begin
                        state_q <= PU_DRAIN_SEND;
                        idx_q   <= idx_q;
                    end
                end
                default: begin
                    state_q <= PU_DRAIN_IDLE;
                    idx_q   <= '0;
                end
            endcase
            if (drop_set_s) begin
                drop_q <= 1'b1;
            end else if (CLR_DROP) begin
                drop_q <= 1'b0;
            end else begin
                drop_q <= drop_q;
            end
        end
    end

    assign word_ext_s = PU_NARROW_W'($signed(rd_word_s));

    assign M_VALID = (state_q == PU_DRAIN_SEND);
    assign BUSY    = (state_q == PU_DRAIN_SEND);
    assign M_IDX   = idx_q;
    assign M_LAST  = (state_q == PU_DRAIN_SEND) & last_s;
    assign M_DATA  = WIDTH_RES'(pu_drain_narrow(word_ext_s, WIDTH_RES));
    assign DROP    = drop_q;

endmodule

// File: tb/tb_pu_result_drain.sv
// Directed bench for pu_result_drain with a queue scoreboard and an independent output monitor.
module tb_pu_result_drain;

    localparam int WO = 32;
    localparam int WR = 16;
    localparam int MR = 8;

    logic            CLK = 1'b0;
    logic            RSTN;
    logic [WO*MR-1:0] PU_OUT;
    logic            PU_DONE;
    logic            M_VALID;
    logic            M_READY;
    logic [WR-1:0]   M_DATA;
    logic [2:0]      M_IDX;
    logic            M_LAST;
    logic            BUSY;
    logic            DROP;
    logic            CLR_DROP;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  idx;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic [2:0]  prev_idx;
    logic        prev_last;

    pu_result_drain #(
        .WIDTH_OUT  (WO),
        .WIDTH_RES  (WR),
        .MATRIX_ROW (MR)
    ) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .PU_OUT   (PU_OUT),
        .PU_DONE  (PU_DONE),
        .M_VALID  (M_VALID),
        .M_READY  (M_READY),
        .M_DATA   (M_DATA),
        .M_IDX    (M_IDX),
        .M_LAST   (M_LAST),
        .BUSY     (BUSY),
        .DROP     (DROP),
        .CLR_DROP (CLR_DROP)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_word(input int k, input logic [31:0] w, input logic [15:0] e, input bit push);
        PU_OUT[WO*k +: WO] = w;
        if (push) exp_q.push_back({e, 3'(k), (k == MR - 1)});
    endtask

    // Linear job: word k = base + k; the narrowed value fits, so both builds agree.
    task automatic load_linear(input logic [31:0] base, input int n_push);
        for (int k = 0; k < MR; k++) begin
            set_word(k, base + 32'(k), base[15:0] + 16'(k), k < n_push);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40 && BUSY; i++) step();
        check(name, 32'(BUSY), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stability under stall.
    always @(negedge CLK) begin
        if (prev_stall) begin
            check("stall_valid", 32'(M_VALID), 32'd1);
            check("stall_data",  32'(M_DATA),  32'(prev_data));
            check("stall_idx",   32'(M_IDX),   32'(prev_idx));
            check("stall_last",  32'(M_LAST),  32'(prev_last));
        end
        if (RSTN && M_VALID && M_READY) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got data 0x%0h idx %0d, expected no word", M_DATA, M_IDX);
            end else begin
                mon_e = exp_q.pop_front();
                check("m_data", 32'(M_DATA), 32'(mon_e.data));
                check("m_idx",  32'(M_IDX),  32'(mon_e.idx));
                check("m_last", 32'(M_LAST), 32'(mon_e.last));
            end
        end
        prev_stall = RSTN && M_VALID && !M_READY;
        prev_data  = M_DATA;
        prev_idx   = M_IDX;
        prev_last  = M_LAST;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RSTN     = 1'b0;
        PU_DONE  = 1'b0;
        M_READY  = 1'b1;
        CLR_DROP = 1'b0;
        PU_OUT   = '0;
        step();
        step();
        check("rst_valid", 32'(M_VALID), 32'd0);
        check("rst_data",  32'(M_DATA),  32'd0);
        check("rst_idx",   32'(M_IDX),   32'd0);
        check("rst_last",  32'(M_LAST),  32'd0);
        check("rst_busy",  32'(BUSY),    32'd0);
        check("rst_drop",  32'(DROP),    32'd0);

        // Capture words 1..8 with ready held high.
        RSTN = 1'b1;
        load_linear(32'd1, MR);
        PU_DONE = 1'b1;
        step();
        check("lat_valid", 32'(M_VALID), 32'd1);
        check("lat_idx",   32'(M_IDX),   32'd0);
        check("lat_busy",  32'(BUSY),    32'd1);
        wait_idle("cap_idle");

        // Backpressure: ready toggles every cycle.
        PU_DONE = 1'b0;
        M_READY = 1'b0;
        step();
        load_linear(32'h0000_0100, MR);
        PU_DONE = 1'b1;
        step();
        for (int i = 0; i < 40 && BUSY; i++) begin
            M_READY = (i % 2 == 0);
            step();
        end
        M_READY = 1'b1;
        check("bp_idle", 32'(BUSY), 32'd0);

        // Narrowing corner values.
        PU_DONE = 1'b0;
        step();
`ifdef PU_DRAIN_SAT_EN
        set_word(0, 32'h0001_0000, 16'h7FFF, 1'b1);
        set_word(1, 32'hFFFE_0000, 16'h8000, 1'b1);
        set_word(4, 32'hFFFF_7FFF, 16'h8000, 1'b1);
`else
        set_word(0, 32'h0001_0000, 16'h0000, 1'b1);
        set_word(1, 32'hFFFE_0000, 16'h0000, 1'b1);
        set_word(4, 32'hFFFF_7FFF, 16'h7FFF, 1'b1);
`endif
        set_word(2, 32'h0000_7FFF, 16'h7FFF, 1'b1);
        set_word(3, 32'hFFFF_8000, 16'h8000, 1'b1);
        set_word(5, 32'h0000_0012, 16'h0012, 1'b1);
        set_word(6, 32'hFFFF_FFFF, 16'hFFFF, 1'b1);
        set_word(7, 32'h0000_0034, 16'h0034, 1'b1);
        // scoreboard must be in index order: reorder entries 2..4
        exp_q.delete();
`ifdef PU_DRAIN_SAT_EN
        exp_q.push_back({16'h7FFF, 3'd0, 1'b0});
        exp_q.push_back({16'h8000, 3'd1, 1'b0});
`else
        exp_q.push_back({16'h0000, 3'd0, 1'b0});
        exp_q.push_back({16'h0000, 3'd1, 1'b0});
`endif
        exp_q.push_back({16'h7FFF, 3'd2, 1'b0});
        exp_q.push_back({16'h8000, 3'd3, 1'b0});
`ifdef PU_DRAIN_SAT_EN
        exp_q.push_back({16'h8000, 3'd4, 1'b0});
`else
        exp_q.push_back({16'h7FFF, 3'd4, 1'b0});
`endif
        exp_q.push_back({16'h0012, 3'd5, 1'b0});
        exp_q.push_back({16'hFFFF, 3'd6, 1'b0});
        exp_q.push_back({16'h0034, 3'd7, 1'b1});
        PU_DONE = 1'b1;
        step();
        wait_idle("sat_idle");

        // Back-to-back: second edge lands on the last handshake.
        PU_DONE = 1'b0;
        step();
        load_linear(32'h0000_0200, MR);
        PU_DONE = 1'b1;
        step();
        PU_DONE = 1'b0;
        for (int i = 0; i < MR - 1; i++) step();
        check("b2b_pre_idx", 32'(M_IDX), 32'd7);
        load_linear(32'h0000_0300, MR);
        PU_DONE = 1'b1;
        step();
        check("b2b_valid", 32'(M_VALID), 32'd1);
        check("b2b_idx",   32'(M_IDX),   32'd0);
        check("b2b_drop",  32'(DROP),    32'd0);
        wait_idle("b2b_idle");
        check("b2b_drop_end", 32'(DROP), 32'd0);

        // Drop: edge while word 3 is presented.
        PU_DONE = 1'b0;
        step();
        load_linear(32'h0000_0400, MR);
        PU_DONE = 1'b1;
        step();
        PU_DONE = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("drop_pre_idx", 32'(M_IDX), 32'd3);
        load_linear(32'h0000_4400, 0);
        PU_DONE = 1'b1;
        step();
        check("drop_set", 32'(DROP),  32'd1);
        check("drop_idx", 32'(M_IDX), 32'd4);
        wait_idle("drop_idle");
        check("drop_sticky", 32'(DROP), 32'd1);
        CLR_DROP = 1'b1;
        step();
        CLR_DROP = 1'b0;
        check("drop_clr", 32'(DROP), 32'd0);

        // Reset in the middle of a drain, DONE still high.
        PU_DONE = 1'b0;
        step();
        load_linear(32'h0000_0500, 2);
        PU_DONE = 1'b1;
        step();
        step();
        step();
        check("rstmid_idx", 32'(M_IDX), 32'd2);
        RSTN    = 1'b0;
        M_READY = 1'b0;
        step();
        check("rstmid_valid", 32'(M_VALID), 32'd0);
        check("rstmid_busy",  32'(BUSY),    32'd0);
        check("rstmid_data",  32'(M_DATA),  32'd0);
        load_linear(32'h0000_0600, MR);
        RSTN    = 1'b1;
        M_READY = 1'b1;
        step();
        check("postrst_valid", 32'(M_VALID), 32'd1);
        check("postrst_idx",   32'(M_IDX),   32'd0);
        wait_idle("postrst_idle");

        step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
